// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks.
// Holds the control state encoding and counter sizing.
package serial_arith_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Counter width: at least one bit even for a single chunk.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One chunk of a ripple add/subtract datapath.
// Exposes the carry into the top bit for overflow detection.
module addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         inv,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cin_msb
);

  logic [W-1:0] bx;
  logic [W:0]   sum;

  // Invert b for subtraction; the +1 comes in via cin.
  always_comb begin
    bx      = b ^ {W{inv}};
    sum     = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    s       = sum[W-1:0];
    cout    = sum[W];
    cin_msb = sum[W-1] ^ a[W-1] ^ bx[W-1];
  end

endmodule

// File: rtl/serial_addsub_chunked.sv
// Chunk-serial add/sub for wide operands, LSB chunk first.
// Carry is held in a register across accepted beats.
module serial_addsub_chunked
  import serial_arith_pkg::*;
#(
  parameter int WORD_W  = 8,
  parameter int N_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] c,
  output logic              c_valid,
  output logic              c_last,
  output logic              carry_out,
  output logic              overflow
);

  localparam int CW = cnt_w(N_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_WORDS - 1);

  state_t        state;
  logic [CW-1:0] count;
  logic          carry;
  logic          mode;

  logic [WORD_W-1:0] s;
  logic              cout;
  logic              cin_msb;
  logic              last_beat;

  addsub_slice #(
    .W(WORD_W)
  ) u_slice (
    .a       (a),
    .b       (b),
    .cin     (carry),
    .inv     (mode),
    .s       (s),
    .cout    (cout),
    .cin_msb (cin_msb)
  );

  // Ready is a pure decode of the registered state.
  always_comb begin
    in_ready  = (state == ST_RUN);
    last_beat = (count == LAST_IDX);
  end

  // Control FSM, chunk counter, carry chain and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      carry     <= 1'b0;
      mode      <= 1'b0;
      c         <= '0;
      c_valid   <= 1'b0;
      c_last    <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      c_valid <= 1'b0;
      c_last  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            mode      <= sub;
            carry     <= sub;
            count     <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            c       <= s;
            c_valid <= 1'b1;
            carry   <= cout;
            if (last_beat) begin
              c_last    <= 1'b1;
              carry_out <= cout;
              overflow  <= cin_msb ^ cout;
              count     <= '0;
              state     <= ST_IDLE;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_chunked.sv
// Scoreboard bench for the chunk-serial add/sub block.
// Wide instance 8x16 plus a single-chunk 4-bit instance.
module tb_serial_addsub_chunked;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] c;
  logic       c_valid;
  logic       c_last;
  logic       carry_out;
  logic       overflow;

  logic       start1;
  logic       sub1;
  logic       in_valid1;
  logic       in_ready1;
  logic [3:0] a1;
  logic [3:0] b1;
  logic [3:0] c1;
  logic       c_valid1;
  logic       c_last1;
  logic       carry_out1;
  logic       overflow1;

  exp_t q[$];
  int   total;
  int   bad;

  serial_addsub_chunked #(
    .WORD_W (8),
    .N_WORDS(16)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .c_valid  (c_valid),
    .c_last   (c_last),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  serial_addsub_chunked #(
    .WORD_W (4),
    .N_WORDS(1)
  ) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .start    (start1),
    .sub      (sub1),
    .in_valid (in_valid1),
    .in_ready (in_ready1),
    .a        (a1),
    .b        (b1),
    .c        (c1),
    .c_valid  (c_valid1),
    .c_last   (c_last1),
    .carry_out(carry_out1),
    .overflow (overflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Drive one wide operation; abort_at >= 0 pulls reset on that beat.
  task automatic run_wide(input string name, input logic [127:0] opa,
                          input logic [127:0] opb, input logic m,
                          input logic [15:0] stall_mask, input int abort_at);
    logic [128:0] full;
    logic         ov_e;
    exp_t         e;
    logic [7:0]   held;
    if (m) full = {1'b0, opa} + {1'b0, ~opb} + 129'd1;
    else   full = {1'b0, opa} + {1'b0, opb};
    ov_e = (opa[127] == (opb[127] ^ m)) && (full[127] != opa[127]);
    held = 8'h00;
    @(negedge clk);
    start = 1'b1;
    sub = m;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL %s start: in_ready=%b carry_out=%b overflow=%b want 1 0 0",
               name, in_ready, carry_out, overflow);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      start = (k == 15);
      sub = 1'($urandom);
      in_valid = 1'b1;
      a = opa[k*8 +: 8];
      b = opb[k*8 +: 8];
      if (k == abort_at) begin
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (c_valid !== 1'b0 || c_last !== 1'b0 || c !== 8'h00 ||
            in_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s abort: c_valid=%b c_last=%b c=%h in_ready=%b want 0 0 00 0",
                   name, c_valid, c_last, c, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        q.delete();
        return;
      end
      q.push_back('{d: full[k*8 +: 8], last: (k == 15)});
      @(posedge clk);
      #1;
      total++;
      e = q.pop_front();
      if (c_valid !== 1'b1 || c !== e.d || c_last !== e.last) begin
        bad++;
        $display("FAIL %s chunk%0d: c_valid=%b c=%h c_last=%b want 1 %h %b",
                 name, k, c_valid, c, c_last, e.d, e.last);
      end
      held = e.d;
      if (k == 15) begin
        total++;
        if (carry_out !== full[128] || overflow !== ov_e || in_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s flags: carry_out=%b overflow=%b in_ready=%b want %b %b 0",
                   name, carry_out, overflow, in_ready, full[128], ov_e);
        end
      end else if (stall_mask[k]) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          in_valid = 1'b0;
          a = 8'($urandom);
          b = 8'($urandom);
          @(posedge clk);
          #1;
          total++;
          if (c_valid !== 1'b0 || c !== held || c_last !== 1'b0) begin
            bad++;
            $display("FAIL %s stall%0d.%0d: c_valid=%b c=%h c_last=%b want 0 %h 0",
                     name, k, s, c_valid, c, c_last, held);
          end
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || c_valid !== 1'b0 || carry_out !== full[128] ||
        overflow !== ov_e) begin
      bad++;
      $display("FAIL %s after: in_ready=%b c_valid=%b carry_out=%b overflow=%b want 0 0 %b %b",
               name, in_ready, c_valid, carry_out, overflow, full[128], ov_e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    in_valid = 1'b1;
    start1 = 1'b1;
    in_valid1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || c !== 8'h00 || c_valid !== 1'b0 || c_last !== 1'b0 ||
        carry_out !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_wide: rdy=%b c=%h cv=%b cl=%b co=%b ov=%b want all 0",
               in_ready, c, c_valid, c_last, carry_out, overflow);
    end
    total++;
    if (in_ready1 !== 1'b0 || c1 !== 4'h0 || c_valid1 !== 1'b0 || c_last1 !== 1'b0 ||
        carry_out1 !== 1'b0 || overflow1 !== 1'b0) begin
      bad++;
      $display("FAIL reset_n1: rdy=%b c=%h cv=%b cl=%b co=%b ov=%b want all 0",
               in_ready1, c1, c_valid1, c_last1, carry_out1, overflow1);
    end
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    start1 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic test_add_carry();
    run_wide("add_carry", {128{1'b1}}, 128'd1, 1'b0, 16'h0000, -1);
  endtask

  task automatic test_sub_borrow();
    run_wide("sub_borrow", 128'd5, 128'd7, 1'b1, 16'h0000, -1);
  endtask

  task automatic test_overflow();
    run_wide("add_ovf", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 16'h0000, -1);
  endtask

  task automatic test_stalls();
    logic [127:0] ra;
    logic [127:0] rb;
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_wide("stall_add", ra, rb, 1'b0, 16'h0204, -1);
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    run_wide("stall_sub", ra, rb, 1'b1, 16'h0204, -1);
  endtask

  task automatic test_abort();
    logic [127:0] ra;
    ra = {$urandom, $urandom, $urandom, 32'hFFFF_FFFF};
    run_wide("abort", ra, {128{1'b1}}, 1'b0, 16'h0000, 7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (c_last !== 1'b0 || c_valid !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL abort_idle%0d: c_last=%b c_valid=%b in_ready=%b want 0 0 0",
                 i, c_last, c_valid, in_ready);
      end
    end
    run_wide("post_abort", 128'd1, 128'd1, 1'b0, 16'h0000, -1);
  endtask

  task automatic test_single_word();
    logic [4:0] full;
    logic       ov_e;
    exp_t       e;
    full = {1'b0, 4'h8} + {1'b0, ~4'h1} + 5'd1;
    ov_e = (1'b1 != 1'b0) && (full[3] != 1'b1);
    @(negedge clk);
    start1 = 1'b1;
    sub1 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start1 = 1'b0;
    sub1 = 1'b0;
    in_valid1 = 1'b1;
    a1 = 4'h8;
    b1 = 4'h1;
    q.push_back('{d: {4'h0, full[3:0]}, last: 1'b1});
    @(posedge clk);
    #1;
    total++;
    e = q.pop_front();
    if (c_valid1 !== 1'b1 || c1 !== e.d[3:0] || c_last1 !== e.last) begin
      bad++;
      $display("FAIL n1_chunk: c_valid=%b c=%h c_last=%b want 1 %h %b",
               c_valid1, c1, c_last1, e.d[3:0], e.last);
    end
    total++;
    if (carry_out1 !== full[4] || overflow1 !== ov_e || in_ready1 !== 1'b0) begin
      bad++;
      $display("FAIL n1_flags: carry_out=%b overflow=%b in_ready=%b want %b %b 0",
               carry_out1, overflow1, in_ready1, full[4], ov_e);
    end
    @(negedge clk);
    in_valid1 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    start1 = 1'b0;
    sub1 = 1'b0;
    in_valid1 = 1'b0;
    a1 = 4'h0;
    b1 = 4'h0;
    test_reset();
    test_add_carry();
    test_sub_borrow();
    test_overflow();
    test_stalls();
    test_abort();
    test_single_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
